spi_master_tx: RTL and testbench
================================

# spi_master_tx

SPI master that serialises 32-bit words onto SCK/SSEL/MOSI for the downstream `spi_slave` receive stage and optionally captures the word returned on MISO. Sits between the on-chip word producer (valid/ready handshake) and the SPI pins. One word per SSEL assertion, MSB first, with SSEL dropped between words so the slave's bit counter realigns on every word.

## Interface
Parameters:
- `WIDTH`, 32, bits per word (fixed per SSEL frame).
- `CLK_DIV`, 4, `clk` cycles per SCK half-period; legal range 4..255.

Ports:
- `clk`  in  1  system clock; one clock domain, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tx_valid`  in  1  producer has a word on `tx_data`.
- `tx_data`  in  WIDTH  word to send.
- `tx_ready`  out  1  block is idle and accepts a word this cycle.
- `SCK`  out  1  SPI clock, idle low.
- `SSEL`  out  1  slave select, active high.
- `MOSI`  out  1  serial data to slave.
- `MISO`  in  1  serial data from slave (used only with `SPI_MASTER_RX_EN`).
- `rx_valid`  out  1  one-cycle pulse: `rx_data` holds a completed word.
- `rx_data`  out  WIDTH  last word captured from MISO.

## Operation
- SPI mode: CPOL=0, CPHA=1. MOSI changes on SCK rising edge; the slave samples on the SCK falling edge; the master samples MISO on its own SCK falling edge.
- Handshake: transfer accepted on the cycle with `tx_valid && tx_ready`. `tx_data` is latched into the shift register that cycle; later changes are ignored.
- FSM states:
  - IDLE: `tx_ready`=1, SSEL=0, SCK=0. Leaves on accept -> SETUP.
  - SETUP: SSEL=1, SCK=0, MOSI=0, CLK_DIV cycles -> HIGH.
  - HIGH: SCK=1, MOSI = current MSB, CLK_DIV cycles -> LOW.
  - LOW: SCK=0, MISO shifted into the rx register at entry, CLK_DIV cycles. Then bit counter += 1; counter == WIDTH -> HOLD, else HIGH.
  - HOLD: SSEL=1, SCK=0, CLK_DIV cycles -> GAP. `rx_valid` pulses on the last HOLD cycle.
  - GAP: SSEL=0, CLK_DIV cycles -> IDLE.
- Bit counter: `$clog2(WIDTH)+1` bits, cleared in SETUP. Divider counter: 8 bits, cleared on every state change.
- MOSI holds its last value in HOLD and returns to 0 in GAP/IDLE.
- Reset values: `tx_ready`=0 while `rst` is high, `SCK`=0, `SSEL`=0, `MOSI`=0, `rx_valid`=0, `rx_data`=0; state IDLE.
- Reset mid-frame: on the `rst` edge, SSEL and SCK go low, the frame is abandoned, no `rx_valid` pulse. The slave drops the partial word because SSEL is deasserted.
- `tx_valid` during a busy frame: ignored (`tx_ready`=0), not queued.

## Timing
- Accept at cycle 0 -> SSEL high at cycle 1.
- First SCK rise at cycle 1+CLK_DIV.
- Bit k (k=0 is the MSB) rises at cycle 1+CLK_DIV·(1+2k) and falls at 1+CLK_DIV·(2+2k).
- `rx_valid` at cycle CLK_DIV·(2·WIDTH+2). SSEL falls at the next cycle.
- `tx_ready` returns at cycle 1+CLK_DIV·(2·WIDTH+3).
- Word period: 67·CLK_DIV+1 cycles for WIDTH=32, CLK_DIV=4, i.e. 269 cycles.
- CLK_DIV ≥ 4 guarantees each SCK level lasts at least the slave's 2-flop synchroniser depth plus margin. MOSI is stable ≥ CLK_DIV cycles before and after each falling edge.
- Back-to-back words: the next accept can occur on the first IDLE cycle. No combinational path from `tx_valid` to `tx_ready`.

## Configuration
- `SPI_MASTER_RX_EN` defined: MISO is sampled at each LOW entry into an rx shift register, MSB first. `rx_data` is updated and `rx_valid` pulses at the end of every complete frame.
- Not defined: no rx shift register; `MISO` is unused; `rx_data` ties to 0. `rx_valid` still pulses at frame end as a "word sent" strobe.

## Test plan
- Reset then idle: hold `rst` 3 cycles -> SCK=SSEL=MOSI=0, `rx_valid`=0; `tx_ready`=1 on the first cycle after release.
- Single word: send 0xA5C3_0F81 with CLK_DIV=4 -> SSEL high for 32 SCK pulses; MOSI sampled at the falling edges reads 0xA5C3_0F81 MSB first; `tx_ready` back at cycle 269.
- Loopback (RX_EN, MISO tied to MOSI): send 0xDEAD_BEEF -> `rx_valid` one cycle, `rx_data`=0xDEAD_BEEF.
- End-to-end with `spi_slave`: send 0x0000_0001 then 0xFFFF_FFFF back-to-back -> slave `out_ready` pulses twice with `out`=0x0000_0001 and then 0xFFFF_FFFF; SSEL low ≥ 4 cycles between frames.
- Reset mid-frame: assert `rst` after the 10th SCK rise -> SSEL/SCK low on the next edge, no `rx_valid`; the next word 0x1234_5678 is received intact.
- Busy ignore: hold `tx_valid` high with changing `tx_data` during a frame -> only the word present at the accept cycle is transmitted; the next word is accepted on the first IDLE cycle.

Source files
------------

// File: rtl/spi_master_tx.sv
// SPI master (CPOL=0, CPHA=1): one WIDTH-bit word per SSEL frame, MSB first.
// Define SPI_MASTER_RX_EN to capture the MISO word; otherwise rx_data reads 0.
module spi_master_tx #(
    parameter int WIDTH   = 32,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_ready,
    output logic             SCK,
    output logic             SSEL,
    output logic             MOSI,
    input  logic             MISO,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data
);

    localparam int BW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_HOLD,
        S_GAP
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       div_q, div_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic             div_done;
    logic             accept;

    assign div_done = (div_q == 8'(CLK_DIV - 1));
    assign accept   = tx_valid && tx_ready;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        tx_sh_d = tx_sh_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    tx_sh_d = tx_data;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                bit_d = '0;
                if (div_done) state_d = S_HIGH;
            end
            S_HIGH: begin
                if (div_done) state_d = S_LOW;
            end
            S_LOW: begin
                if (div_done) begin
                    bit_d = bit_q + 1'b1;
                    // Shift only between bits so MOSI keeps the last bit through HOLD.
                    if (bit_q == BW'(WIDTH - 1)) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_HIGH;
                        tx_sh_d = {tx_sh_q[WIDTH-2:0], 1'b0};
                    end
                end
            end
            S_HOLD: begin
                if (div_done) state_d = S_GAP;
            end
            S_GAP: begin
                if (div_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        div_d = (state_d != state_q) ? 8'd0 : div_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            div_q   <= 8'd0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
        end
    end

    always_ff @(posedge clk) begin
        tx_sh_q <= tx_sh_d;
    end

    // Pin outputs decode directly from the state register (no tx_valid -> tx_ready path).
    assign tx_ready = (state_q == S_IDLE) && !rst;
    assign SCK      = (state_q == S_HIGH);
    assign SSEL     = (state_q inside {S_SETUP, S_HIGH, S_LOW, S_HOLD});
    assign MOSI     = (state_q inside {S_HIGH, S_LOW, S_HOLD}) && tx_sh_q[WIDTH-1];
    assign rx_valid = (state_q == S_HOLD) && div_done;

`ifdef SPI_MASTER_RX_EN
    logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;

    always_comb begin
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        if (state_q == S_HIGH && state_d == S_LOW) begin
            rx_sh_d = {rx_sh_q[WIDTH-2:0], MISO};
        end
        if (state_q == S_LOW && state_d == S_HOLD) begin
            rx_data_d = rx_sh_q;
        end
    end

    always_ff @(posedge clk) begin
        rx_sh_q <= rx_sh_d;
        if (rst) begin
            rx_data_q <= '0;
        end else begin
            rx_data_q <= rx_data_d;
        end
    end

    assign rx_data = rx_data_q;
`else
    logic unused_miso;
    assign unused_miso = MISO;
    assign rx_data     = '0;
`endif

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx: frame timing, MOSI serialisation, rx strobe,
// busy-ignore, back-to-back and mid-frame reset.
module tb_spi_master_tx;

    localparam int WIDTH   = 32;
    localparam int CLK_DIV = 4;
`ifdef SPI_MASTER_RX_EN
    localparam bit RXEN = 1'b1;
`else
    localparam bit RXEN = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             tx_valid;
    logic [WIDTH-1:0] tx_data;
    logic             tx_ready;
    logic             SCK;
    logic             SSEL;
    logic             MOSI;
    logic             MISO;
    logic             rx_valid;
    logic [WIDTH-1:0] rx_data;
    logic             loop_en;

    assign MISO = loop_en & MOSI;

    spi_master_tx #(.WIDTH(WIDTH), .CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .SCK      (SCK),
        .SSEL     (SSEL),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_valid (rx_valid),
        .rx_data  (rx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] data;
        bit          loop;
        bit          noise;
        logic [31:0] exp_word;
        logic [31:0] exp_rx;
    } vec_t;

    vec_t vecs[6];

    // Sends one word and checks the whole frame, with t=0 the accept cycle.
    task automatic send_frame(input string tag, input logic [31:0] data, input bit loop,
                              input bit noise, input logic [31:0] exp_word,
                              input logic [31:0] exp_rx);
        int wait_n = 0;
        int ssel_rise = -1, first_rise = -1, ssel_fall = -1, rxv_t = -1, ready_t = -1;
        int falls = 0, pulses = 0, busy_ready = 0;
        logic [31:0] cap = '0;
        logic [31:0] rxd = '0;
        logic prev_sck = 1'b0;
        loop_en  = loop;
        tx_data  = data;
        tx_valid = 1'b1;
        while (!tx_ready && wait_n < 400) begin
            tick();
            wait_n++;
        end
        chk($sformatf("%s accept_wait", tag), wait_n, 0);
        tick();
        if (noise) tx_data = $urandom;
        else tx_valid = 1'b0;
        for (int t = 1; t <= 400; t++) begin
            if (SSEL && ssel_rise < 0) ssel_rise = t;
            if (SCK && !prev_sck && first_rise < 0) first_rise = t;
            if (!SCK && prev_sck) begin
                cap = {cap[30:0], MOSI};
                falls++;
            end
            if (rx_valid) begin
                pulses++;
                if (rxv_t < 0) begin
                    rxv_t = t;
                    rxd   = rx_data;
                end
            end
            if (!SSEL && ssel_rise >= 0 && ssel_fall < 0) ssel_fall = t;
            if (tx_ready) begin
                ready_t = t;
                break;
            end
            if (t < 1 + CLK_DIV * (2 * WIDTH + 3) && tx_ready) busy_ready++;
            prev_sck = SCK;
            if (noise) tx_data = $urandom;
            tick();
        end
        chk($sformatf("%s ssel_rise", tag), ssel_rise, 1);
        chk($sformatf("%s first_sck_rise", tag), first_rise, 1 + CLK_DIV);
        chk($sformatf("%s sck_falls", tag), falls, WIDTH);
        chk($sformatf("%s mosi_word", tag), cap, exp_word);
        chk($sformatf("%s rx_valid_cycle", tag), rxv_t, CLK_DIV * (2 * WIDTH + 2));
        chk($sformatf("%s rx_valid_pulses", tag), pulses, 1);
        chk($sformatf("%s rx_data", tag), rxd, exp_rx);
        chk($sformatf("%s ssel_fall", tag), ssel_fall, CLK_DIV * (2 * WIDTH + 2) + 1);
        chk($sformatf("%s ready_cycle", tag), ready_t, 1 + CLK_DIV * (2 * WIDTH + 3));
        chk($sformatf("%s busy_ready", tag), busy_ready, 0);
    endtask

    initial begin
        int n;
        int rises;
        int pulse_seen;
        logic prev;

        vecs[0] = '{32'hA5C3_0F81, 1'b0, 1'b0, 32'hA5C3_0F81, 32'h0};
        vecs[1] = '{32'hDEAD_BEEF, 1'b1, 1'b0, 32'hDEAD_BEEF, RXEN ? 32'hDEAD_BEEF : 32'h0};
        vecs[2] = '{32'h0000_0001, 1'b0, 1'b0, 32'h0000_0001, 32'h0};
        vecs[3] = '{32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, RXEN ? 32'hFFFF_FFFF : 32'h0};
        vecs[4] = '{32'h0F0F_1234, 1'b0, 1'b1, 32'h0F0F_1234, 32'h0};
        vecs[5] = '{32'h5A5A_C3C3, 1'b1, 1'b0, 32'h5A5A_C3C3, RXEN ? 32'h5A5A_C3C3 : 32'h0};

        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        loop_en  = 1'b0;
        tick();
        tick();
        tick();
        chk("reset tx_ready", tx_ready, 0);
        chk("reset SCK", SCK, 0);
        chk("reset SSEL", SSEL, 0);
        chk("reset MOSI", MOSI, 0);
        chk("reset rx_valid", rx_valid, 0);
        chk("reset rx_data", rx_data, 0);
        rst = 1'b0;
        #1;
        chk("release tx_ready", tx_ready, 1);

        for (int i = 0; i < 6; i++) begin
            send_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].loop, vecs[i].noise,
                       vecs[i].exp_word, vecs[i].exp_rx);
        end
        tx_valid = 1'b0;

        // Abandon a frame just after the 10th SCK rise.
        loop_en  = 1'b1;
        tx_data  = 32'hFFFF_FFFF;
        tx_valid = 1'b1;
        n = 0;
        while (!tx_ready && n < 400) begin
            tick();
            n++;
        end
        tick();
        tx_valid   = 1'b0;
        rises      = 0;
        pulse_seen = 0;
        prev       = 1'b0;
        n          = 0;
        while (rises < 10 && n < 400) begin
            if (SCK && !prev) rises++;
            prev = SCK;
            if (rx_valid) pulse_seen++;
            if (rises < 10) tick();
            n++;
        end
        chk("midrst sck_rises", rises, 10);
        rst = 1'b1;
        tick();
        chk("midrst SSEL", SSEL, 0);
        chk("midrst SCK", SCK, 0);
        chk("midrst rx_valid", rx_valid, 0);
        chk("midrst tx_ready", tx_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("midrst release tx_ready", tx_ready, 1);
        chk("midrst rx_data", rx_data, 0);
        chk("midrst no_pulse", pulse_seen, 0);
        send_frame("after_rst", 32'h1234_5678, 1'b1, 1'b0, 32'h1234_5678,
                   RXEN ? 32'h1234_5678 : 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
